// File: rtl/lattice_reader.sv
// Streams one lattice frame out of BRAM and reduces each 9-distribution point to density and x-momentum.
// Optional momentum path: define LATTICE_READER_MOMENTUM_EN.
module lattice_reader #(
  parameter int BRAM_DEPTH    = 31570,
  parameter int LATTICE_WIDTH = 205,
  parameter int READ_LATENCY  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [$clog2(BRAM_DEPTH)-1:0] addr_out,
  input  logic [8:0][7:0]               bram_data_in,
  output logic [11:0]                   pixel_density_out,
  output logic signed [10:0]            pixel_momentum_out,
  output logic                          pixel_valid_out,
  input  logic                          pixel_ready_in,
  output logic                          pixel_row_end_out,
  output logic                          pixel_last_out
);

  localparam int AW         = $clog2(BRAM_DEPTH);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 2) + 1;
  localparam int XW         = (LATTICE_WIDTH > 1) ? $clog2(LATTICE_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
  localparam logic [XW-1:0] LAST_COL  = XW'(LATTICE_WIDTH - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           addr;
  logic                    issue;
  logic                    credit;
  logic [READ_LATENCY-1:0] vsr;
  logic                    ret;
  logic                    conv_valid;
  logic [11:0]             conv_den;
  logic [11:0]             den_sum;
  logic [11:0]             fifo_den [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           inflight;
  logic                    push, pop;
  logic [AW-1:0]           pix_idx;
  logic [XW-1:0]           pix_col;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    case (state)
      IDLE:  if (start_in) state_nxt = READ;
      READ: begin
        busy_out = 1'b1;
        if (issue && addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_out = 1'b1;
        if (pop && pix_idx == LAST_ADDR) state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- address issue with credit ----------------
  // Every issued read already owns a FIFO slot; a pop in the same cycle frees one,
  // which is what keeps the stream bubble-free at full rate.
  always_comb begin
    inflight = fifo_count + CW'(conv_valid);
    for (int unsigned i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vsr[i]);
  end

  assign credit   = inflight < (CW'(FIFO_DEPTH) + CW'(pop));
  assign issue    = (state == READ) && credit;
  assign addr_out = addr;

  always_ff @(posedge clk_in) begin
    if (rst_in)              addr <= '0;
    else if (issue)          addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    else if (state != READ)  addr <= '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) vsr <= '0;
    else        vsr <= (vsr << 1) | READ_LATENCY'(issue);
  end

  assign ret = vsr[READ_LATENCY-1];

  // ---------------- conversion stage ----------------
  always_comb begin
    den_sum = '0;
    for (int unsigned i = 0; i < 9; i++) den_sum = den_sum + 12'(bram_data_in[i]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) conv_valid <= 1'b0;
    else        conv_valid <= ret;
  end

  always_ff @(posedge clk_in) begin
    if (ret) conv_den <= den_sum;
  end

  // ---------------- output FIFO ----------------
  assign push            = conv_valid;
  assign pixel_valid_out = (fifo_count != '0);
  assign pop             = pixel_valid_out && pixel_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_den[wr_ptr] <= conv_den;
  end

  assign pixel_density_out = fifo_den[rd_ptr];

`ifdef LATTICE_READER_MOMENTUM_EN
  logic [9:0]         pos_sum, neg_sum;
  logic signed [10:0] mom_diff;
  logic signed [10:0] conv_mom;
  logic signed [10:0] fifo_mom [FIFO_DEPTH];

  assign pos_sum  = 10'(bram_data_in[2]) + 10'(bram_data_in[3]) + 10'(bram_data_in[4]);
  assign neg_sum  = 10'(bram_data_in[6]) + 10'(bram_data_in[7]) + 10'(bram_data_in[8]);
  assign mom_diff = $signed({1'b0, pos_sum}) - $signed({1'b0, neg_sum});

  always_ff @(posedge clk_in) begin
    if (ret) conv_mom <= mom_diff;
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mom[wr_ptr] <= conv_mom;
  end

  assign pixel_momentum_out = fifo_mom[rd_ptr];
`else
  assign pixel_momentum_out = '0;
`endif

  // ---------------- output position tracking ----------------
  // Pixels leave strictly in address order, so row/frame markers come from an output-side counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pix_idx <= '0;
      pix_col <= '0;
    end else if (pop) begin
      pix_idx <= (pix_idx == LAST_ADDR) ? '0 : pix_idx + 1'b1;
      pix_col <= (pix_col == LAST_COL || pix_idx == LAST_ADDR) ? '0 : pix_col + 1'b1;
    end
  end

  assign pixel_row_end_out = pixel_valid_out && (pix_col == LAST_COL);
  assign pixel_last_out    = pixel_valid_out && (pix_idx == LAST_ADDR);

endmodule

// File: tb/tb_lattice_reader.sv
// Directed self-checking bench for lattice_reader with a behavioural two-stage BRAM.
module tb_lattice_reader;

  localparam int DEPTH = 31570;
  localparam int LW    = 205;
  localparam int LAT   = 2;
  localparam int FD    = LAT + 2;
  localparam int AW    = $clog2(DEPTH);

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b1;
  logic                start_in = 1'b0;
  logic                busy_out, done_out;
  logic [AW-1:0]       addr_out;
  logic [8:0][7:0]     bram_data_in;
  logic [8:0][7:0]     bram_d1;
  logic [11:0]         pixel_density_out;
  logic signed [10:0]  pixel_momentum_out;
  logic                pixel_valid_out;
  logic                pixel_ready_in = 1'b1;
  logic                pixel_row_end_out, pixel_last_out;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  always #5 clk_in = ~clk_in;

  lattice_reader #(
    .BRAM_DEPTH   (DEPTH),
    .LATTICE_WIDTH(LW),
    .READ_LATENCY (LAT)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .addr_out          (addr_out),
    .bram_data_in      (bram_data_in),
    .pixel_density_out (pixel_density_out),
    .pixel_momentum_out(pixel_momentum_out),
    .pixel_valid_out   (pixel_valid_out),
    .pixel_ready_in    (pixel_ready_in),
    .pixel_row_end_out (pixel_row_end_out),
    .pixel_last_out    (pixel_last_out)
  );

  // mode 0: all bytes 10; mode 1: E=127, rest 15; mode 2: address-dependent pattern
  function automatic logic [7:0] bval(input int m, input int a, input int i);
    logic [31:0] v;
    case (m)
      0:       v = 32'd10;
      1:       v = (i == 3) ? 32'd127 : 32'd15;
      default: v = 32'(a * (i * 7 + 3) + i * 29);
    endcase
    return v[7:0];
  endfunction

  function automatic logic [8:0][7:0] word(input int m, input int a);
    logic [8:0][7:0] w;
    for (int i = 0; i < 9; i++) w[i] = bval(m, a, i);
    return w;
  endfunction

  function automatic logic [11:0] exp_den(input int m, input int a);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(bval(m, a, i));
    return 12'(s);
  endfunction

  function automatic logic signed [10:0] exp_mom(input int m, input int a);
`ifdef LATTICE_READER_MOMENTUM_EN
    int p, n;
    p = int'(bval(m, a, 2)) + int'(bval(m, a, 3)) + int'(bval(m, a, 4));
    n = int'(bval(m, a, 6)) + int'(bval(m, a, 7)) + int'(bval(m, a, 8));
    return 11'(p - n);
`else
    return 11'(m - m);
`endif
  endfunction

  always @(posedge clk_in) begin
    bram_d1      <= word(mode, int'(addr_out));
    bram_data_in <= bram_d1;
  end

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b0; pixel_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_out); end
    checks++; if (pixel_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", pixel_valid_out); end
    checks++; if (addr_out !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_out); end
    checks++; if (pixel_row_end_out !== 1'b0 || pixel_last_out !== 1'b0) begin
      errors++; $display("FAIL reset_markers: got row_end=%0b last=%0b want 0 0", pixel_row_end_out, pixel_last_out);
    end
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || addr_out !== '0) begin
      errors++; $display("FAIL idle_hold: got busy=%0b addr=%0d want 0 0", busy_out, addr_out);
    end
  endtask

  task automatic test_full_frame();
    int xfer = 0, done_cnt = 0, row_cnt = 0, last_cnt = 0, bubbles = 0, bad_addr = 0;
    int first_lat = -1, prev_addr = 0, last_cyc = -1, done_cyc = -1, extra_valid = 0;
    bit seen_first = 0, got_done = 0, exp_re, exp_last;
    time t0;
    mode = 0; pixel_ready_in = 1'b1;
    @(negedge clk_in); start_in = 1'b1;
    @(posedge clk_in); t0 = $time;
    @(negedge clk_in); start_in = 1'b0;
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL frame_busy_rise: got %0b want 1", busy_out); end
    for (int cyc = 0; cyc < 40000 && !got_done; cyc++) begin
      start_in = (cyc == 600);
      if (pixel_valid_out && !seen_first) begin seen_first = 1; first_lat = int'(($time - t0) / 10); end
      if (seen_first && xfer < DEPTH && !pixel_valid_out) bubbles++;
      if (int'(addr_out) != prev_addr && int'(addr_out) != prev_addr + 1 &&
          !(addr_out == '0 && prev_addr == DEPTH - 1)) bad_addr++;
      prev_addr = int'(addr_out);
      if (done_out) begin
        done_cnt++; got_done = 1; done_cyc = cyc;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL frame_done_busy: got %0b want 0", busy_out); end
      end
      if (pixel_valid_out && pixel_ready_in) begin
        exp_re   = ((xfer + 1) % LW) == 0;
        exp_last = (xfer == DEPTH - 1);
        checks++; if (pixel_density_out !== 12'd90) begin
          errors++; $display("FAIL frame_density[%0d]: got %0d want 90", xfer, pixel_density_out);
        end
        checks++; if (pixel_momentum_out !== 11'sd0) begin
          errors++; $display("FAIL frame_momentum[%0d]: got %0d want 0", xfer, pixel_momentum_out);
        end
        checks++; if (pixel_row_end_out !== exp_re || pixel_last_out !== exp_last) begin
          errors++; $display("FAIL frame_markers[%0d]: got row_end=%0b last=%0b want %0b %0b",
                             xfer, pixel_row_end_out, pixel_last_out, exp_re, exp_last);
        end
        if (pixel_row_end_out) row_cnt++;
        if (pixel_last_out) begin last_cnt++; last_cyc = cyc; end
        xfer++;
      end
      @(negedge clk_in);
    end
    start_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_out) done_cnt++;
      if (pixel_valid_out) extra_valid++;
      @(negedge clk_in);
    end
    checks++; if (!got_done) begin errors++; $display("FAIL frame_timeout: got no done_out want done within 40000 cycles"); end
    checks++; if (first_lat !== 4) begin errors++; $display("FAIL first_valid_latency: got %0d want 4", first_lat); end
    checks++; if (xfer !== DEPTH) begin errors++; $display("FAIL frame_count: got %0d want %0d", xfer, DEPTH); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== last_cyc + 1) begin
      errors++; $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_cyc + 1);
    end
    checks++; if (row_cnt !== DEPTH / LW) begin errors++; $display("FAIL row_end_count: got %0d want %0d", row_cnt, DEPTH / LW); end
    checks++; if (last_cnt !== 1) begin errors++; $display("FAIL last_count: got %0d want 1", last_cnt); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL bubbles: got %0d want 0", bubbles); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL addr_sequence: got %0d bad steps want 0", bad_addr); end
    checks++; if (extra_valid !== 0) begin errors++; $display("FAIL post_frame_valid: got %0d want 0", extra_valid); end
    checks++; if (busy_out !== 1'b0 || addr_out !== '0) begin
      errors++; $display("FAIL post_frame_idle: got busy=%0b addr=%0d want 0 0", busy_out, addr_out);
    end
  endtask

  task automatic test_momentum();
    int xfer = 0;
    mode = 1; pixel_ready_in = 1'b1;
    @(negedge clk_in); start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
    for (int cyc = 0; cyc < 400 && xfer < 200; cyc++) begin
      if (pixel_valid_out && pixel_ready_in) begin
        checks++; if (pixel_density_out !== 12'd247) begin
          errors++; $display("FAIL mom_density[%0d]: got %0d want 247", xfer, pixel_density_out);
        end
        checks++; if (pixel_momentum_out !== exp_mom(1, xfer)) begin
          errors++; $display("FAIL mom_value[%0d]: got %0d want %0d", xfer, pixel_momentum_out, exp_mom(1, xfer));
        end
        xfer++;
      end
      @(negedge clk_in);
    end
    checks++; if (xfer !== 200) begin errors++; $display("FAIL mom_timeout: got %0d pixels want 200", xfer); end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_stall_reset();
    int xfer = 0, prev_addr = 0, bad_done = 0, bad_valid = 0;
    bit stalled = 0, prev_re = 0, prev_last = 0;
    logic [11:0] prev_den = '0;
    logic signed [10:0] prev_mom = '0;
    mode = 2; pixel_ready_in = 1'b0;
    @(negedge clk_in); start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
    for (int cyc = 0; cyc < 6000 && xfer < 1000; cyc++) begin
      if (stalled) begin
        checks++;
        if (pixel_valid_out !== 1'b1 || pixel_density_out !== prev_den || pixel_momentum_out !== prev_mom ||
            pixel_row_end_out !== prev_re || pixel_last_out !== prev_last) begin
          errors++; $display("FAIL stall_hold[%0d]: got v=%0b d=%0d m=%0d want v=1 d=%0d m=%0d",
                             xfer, pixel_valid_out, pixel_density_out, pixel_momentum_out, prev_den, prev_mom);
        end
      end
      checks++; if (int'(addr_out) - xfer > FD || int'(addr_out) < xfer) begin
        errors++; $display("FAIL credit_bound: got %0d outstanding want 0..%0d", int'(addr_out) - xfer, FD);
      end
      checks++; if (int'(addr_out) != prev_addr && int'(addr_out) != prev_addr + 1) begin
        errors++; $display("FAIL stall_addr_step: got %0d want %0d or %0d", addr_out, prev_addr, prev_addr + 1);
      end
      prev_addr = int'(addr_out);
      pixel_ready_in = 1'($urandom_range(0, 1));
      if (pixel_valid_out && pixel_ready_in) begin
        checks++;
        if (pixel_density_out !== exp_den(2, xfer) || pixel_momentum_out !== exp_mom(2, xfer) ||
            pixel_row_end_out !== (((xfer + 1) % LW) == 0)) begin
          errors++; $display("FAIL stall_pixel[%0d]: got d=%0d m=%0d re=%0b want d=%0d m=%0d re=%0b",
                             xfer, pixel_density_out, pixel_momentum_out, pixel_row_end_out,
                             exp_den(2, xfer), exp_mom(2, xfer), ((xfer + 1) % LW) == 0);
        end
        xfer++;
      end
      stalled   = pixel_valid_out && !pixel_ready_in;
      prev_den  = pixel_density_out;
      prev_mom  = pixel_momentum_out;
      prev_re   = pixel_row_end_out;
      prev_last = pixel_last_out;
      @(negedge clk_in);
    end
    checks++; if (xfer !== 1000) begin errors++; $display("FAIL stall_timeout: got %0d pixels want 1000", xfer); end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checks++;
    if (pixel_valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 || addr_out !== '0 ||
        pixel_row_end_out !== 1'b0 || pixel_last_out !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got v=%0b busy=%0b done=%0b addr=%0d want all 0",
                         pixel_valid_out, busy_out, done_out, addr_out);
    end
    pixel_ready_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (done_out) bad_done++;
      if (pixel_valid_out) bad_valid++;
      @(negedge clk_in);
    end
    checks++; if (bad_done !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", bad_done); end
    checks++; if (bad_valid !== 0) begin errors++; $display("FAIL abort_stale_data: got %0d valid cycles want 0", bad_valid); end
  endtask

  task automatic test_restart();
    int xfer = 0;
    mode = 2; pixel_ready_in = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
    checks++; if (addr_out !== '0 || busy_out !== 1'b1) begin
      errors++; $display("FAIL restart_first_addr: got addr=%0d busy=%0b want 0 1", addr_out, busy_out);
    end
    @(negedge clk_in);
    checks++; if (addr_out !== AW'(1)) begin errors++; $display("FAIL restart_second_addr: got %0d want 1", addr_out); end
    for (int cyc = 0; cyc < 600 && xfer < 300; cyc++) begin
      if (pixel_valid_out && pixel_ready_in) begin
        checks++;
        if (pixel_density_out !== exp_den(2, xfer) || pixel_momentum_out !== exp_mom(2, xfer) ||
            pixel_row_end_out !== (((xfer + 1) % LW) == 0) || pixel_last_out !== 1'b0) begin
          errors++; $display("FAIL restart_pixel[%0d]: got d=%0d m=%0d re=%0b want d=%0d m=%0d re=%0b",
                             xfer, pixel_density_out, pixel_momentum_out, pixel_row_end_out,
                             exp_den(2, xfer), exp_mom(2, xfer), ((xfer + 1) % LW) == 0);
        end
        xfer++;
      end
      @(negedge clk_in);
    end
    checks++; if (xfer !== 300) begin errors++; $display("FAIL restart_timeout: got %0d pixels want 300", xfer); end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_momentum();
    test_stall_reset();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lattice_reader.md
LATTICE_READER -- requirements
Module: lattice_reader

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 31570, number of lattice points per frame.
REQ-002 SHALL have parameter LATTICE_WIDTH, default 205, lattice points per row; BRAM_DEPTH is a multiple of LATTICE_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from addr_out to valid bram_data_in.
REQ-004 SHALL have ports: clk_in  input  1  system clock; rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: start_in  input  1  begin one frame read; busy_out  output  1  frame in progress; done_out  output  1  one-cycle frame-complete pulse.
REQ-006 SHALL have ports: addr_out  output  $clog2(BRAM_DEPTH)  lattice read address; bram_data_in  input  9x8  distributions, order center,N,NE,E,SE,S,SW,W,NW.
REQ-007 SHALL have ports: pixel_density_out  output  12  sum of 9 distributions; pixel_momentum_out  output  11 signed  x-momentum; pixel_valid_out  output  1; pixel_ready_in  input  1.
REQ-008 SHALL have ports: pixel_row_end_out  output  1  last point of a row; pixel_last_out  output  1  last point of frame.

Function
REQ-009 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-010 IDLE: start_in high -> READ, busy_out high next cycle; start_in ignored in all other states.
REQ-011 READ: SHALL issue addresses 0..BRAM_DEPTH-1 in order, at most one per cycle, each only when outstanding reads plus FIFO occupancy < FIFO_DEPTH (FIFO_DEPTH = READ_LATENCY+2).
REQ-012 READ -> DRAIN after address BRAM_DEPTH-1 issued; DRAIN -> DONE when last pixel transferred; DONE asserts done_out one cycle, clears busy_out, -> IDLE.
REQ-013 SHALL track in-flight reads with a READ_LATENCY-deep valid shift register; each returning word SHALL be converted and written to the FIFO, never dropped.
REQ-014 Density SHALL be the unsigned 12-bit sum of all 9 bytes (max 2295, no overflow).
REQ-015 Momentum SHALL be (NE+E+SE)-(SW+W+NW), 11-bit two's complement, range -765..765.
REQ-016 Conversion SHALL be one registered stage; first pixel_valid_out at T+READ_LATENCY+2 when start_in sampled at T and pixel_ready_in high.
REQ-017 Output handshake: transfer when pixel_valid_out && pixel_ready_in; all pixel outputs SHALL hold stable while valid && !ready.
REQ-018 With pixel_ready_in held high, throughput SHALL be one pixel per cycle with no bubbles after the first.
REQ-019 pixel_row_end_out SHALL be high with pixel index k where (k+1) mod LATTICE_WIDTH == 0; pixel_last_out high only with index BRAM_DEPTH-1 (also row end).
REQ-020 addr_out SHALL return to 0 and hold when not reading.
REQ-021 FIFO full and a return arriving simultaneously SHALL be impossible by REQ-011 credit rule.

Reset
REQ-022 rst_in SHALL force IDLE, addr_out 0, busy_out 0, done_out 0, pixel_valid_out 0, row_end/last 0, FIFO empty, in-flight reads discarded.
REQ-023 Reset mid-frame SHALL abort the frame with no done_out pulse; data returning after reset SHALL be ignored.

Configuration
REQ-024 Macro LATTICE_READER_MOMENTUM_EN defined: momentum computed, stored in FIFO, driven on pixel_momentum_out.
REQ-025 Macro undefined: no momentum logic or FIFO storage; pixel_momentum_out SHALL be constant 0; all other behaviour identical.

Verification
REQ-026 All bytes 10, ready high, start pulse -> 31570 pixels density 90, momentum 0, first valid 4 cycles after start, done_out once.
REQ-027 E=127, others 15 (macro defined) -> density 247, momentum 112 every pixel; macro undefined -> momentum 0.
REQ-028 Random pixel_ready_in (50%) -> no lost/duplicated pixels, outputs stable during stall, addr_out sequence monotonic, FIFO never overflows.
REQ-029 Full frame -> row_end on indices 204, 409, ... 31569 (154 pulses), last only on 31569.
REQ-030 start_in pulsed mid-frame -> ignored, pixel count stays 31570; rst_in at pixel 1000 -> outputs reset next cycle, no done_out, new start reads from address 0.
